mdr_seq_core: RTL

- Parametrised sequential multiply/divide/square-root engine; next generation of the fixed 10-bit MDR datapath.
- Operands are signed two's complement, loaded serially over one shared data bus under a start/load handshake.
- Computes with iterative shift-add, restoring division and digit-by-digit root, one iteration per clock.
- Flags overflow and illegal operations; sits between the switch/button input logic and the seven-segment display driver.

---
 rtl/mdr_seq_core.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mdr_seq_core.sv
// Sequential signed multiply / divide / square-root engine, one iteration per clock.
// Operands arrive serially on a shared bus. Each operand is captured on a rising edge of load.
module mdr_seq_core #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic [1:0]    op,
  output logic          load_x,
  output logic          load_y,
  output logic          busy,
  output logic          ready,
  output logic          error,
  output logic          overflow,
  output logic [DW-1:0] result,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(DW) + 1;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [2*DW-1:0] POS_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] NEG_MAX = POS_MAX + 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_X, S_LOAD_Y, S_CALC, S_DONE} state_t;
  state_t state, state_nxt;

  logic            load_q, cap, cap_x, cap_y, set_err, calc_last;
  logic [1:0]      op_q;
  logic            sign_x, sign_y, data_neg, neg;
  logic [DW-1:0]   data_mag, mag_x, mag_y;
  logic [2*DW-1:0] acc, acc_nxt, mul_nxt, div_nxt, sq_nxt;
  logic [DW:0]     mul_sum, div_sh;
  logic            div_ge, sq_ge;
  logic [DW-1:0]   div_rem, div_q, div_r;
  logic [DW+1:0]   sq_sh, sq_trial;
  logic [DW-1:0]   root, root_nxt, rrem, rrem_nxt;
  logic [CW-1:0]   cnt, last_cnt;
  logic [DW-1:0]   fin_res, fin_rem;
  logic            fin_ovf;

  assign cap      = load & ~load_q;
  assign data_neg = data[DW-1];
  assign data_mag = data_neg ? -data : data;
  assign last_cnt = (op_q == OP_SQRT) ? CW'(DW/2 - 1) : CW'(DW - 1);

  assign load_x = (state == S_LOAD_X);
  assign load_y = (state == S_LOAD_Y);
  assign busy   = (state == S_CALC);
  assign ready  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_x     = 1'b0;
    cap_y     = 1'b0;
    set_err   = 1'b0;
    calc_last = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD_X;
      S_LOAD_X: begin
        if (cap) begin
          cap_x = 1'b1;
          if (op_q == OP_RSVD || (op_q == OP_SQRT && data_neg)) begin
            set_err   = 1'b1;
            state_nxt = S_DONE;
          end else if (op_q == OP_SQRT) begin
            state_nxt = S_CALC;
          end else begin
            state_nxt = S_LOAD_Y;
          end
        end
      end
      S_LOAD_Y: begin
        if (cap) begin
          cap_y = 1'b1;
          if (op_q == OP_DIV && data == '0) begin
            set_err   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (cnt == last_cnt) begin
          calc_last = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // acc holds {partial product | multiplier} for multiply, {remainder | quotient} for divide,
  // and the radicand (shifted out two bits per step from the top of the low half) for root.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, mag_x} : {(DW+1){1'b0}});
    mul_nxt  = {mul_sum, acc[DW-1:1]};

    div_sh   = {acc[2*DW-1:DW], acc[DW-1]};
    div_ge   = (div_sh >= {1'b0, mag_y});
    div_rem  = div_ge ? (div_sh[DW-1:0] - mag_y) : div_sh[DW-1:0];
    div_nxt  = {div_rem, acc[DW-2:0], div_ge};

    sq_sh    = {rrem, acc[DW-1:DW-2]};
    sq_trial = {root, 2'b01};
    sq_ge    = (sq_sh >= sq_trial);
    rrem_nxt = sq_ge ? (sq_sh[DW-1:0] - sq_trial[DW-1:0]) : sq_sh[DW-1:0];
    root_nxt = {root[DW-2:0], sq_ge};
    sq_nxt   = {acc[2*DW-1:DW], acc[DW-3:0], 2'b00};

    case (op_q)
      OP_MUL:  acc_nxt = mul_nxt;
      OP_DIV:  acc_nxt = div_nxt;
      default: acc_nxt = sq_nxt;
    endcase
  end

  // Signs are reapplied to the final iteration's magnitudes on the exit edge.
  always_comb begin
    neg     = sign_x ^ sign_y;
    div_q   = div_nxt[DW-1:0];
    div_r   = div_nxt[2*DW-1:DW];
    fin_res = '0;
    fin_rem = '0;
    fin_ovf = 1'b0;
    case (op_q)
      OP_MUL: begin
        fin_res = neg ? -mul_nxt[DW-1:0] : mul_nxt[DW-1:0];
        fin_ovf = neg ? (mul_nxt > NEG_MAX) : (mul_nxt > POS_MAX);
      end
      OP_DIV: begin
        fin_res = neg ? -div_q : div_q;
        fin_rem = sign_x ? -div_r : div_r;
        fin_ovf = ~neg & div_q[DW-1];
      end
      default: begin
        fin_res = root_nxt;
        fin_rem = rrem_nxt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q    <= 1'b0;
      op_q      <= '0;
      sign_x    <= 1'b0;
      sign_y    <= 1'b0;
      mag_x     <= '0;
      mag_y     <= '0;
      acc       <= '0;
      root      <= '0;
      rrem      <= '0;
      cnt       <= '0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
      remainder <= '0;
    end else begin
      load_q <= load;
      if (state == S_IDLE && start) begin
        op_q      <= op;
        error     <= 1'b0;
        overflow  <= 1'b0;
        result    <= '0;
        remainder <= '0;
      end
      if (cap_x) begin
        sign_x <= data_neg;
        mag_x  <= data_mag;
        acc    <= {{DW{1'b0}}, data};
        root   <= '0;
        rrem   <= '0;
        cnt    <= '0;
      end
      if (cap_y) begin
        sign_y <= data_neg;
        mag_y  <= data_mag;
        acc    <= (op_q == OP_MUL) ? {{DW{1'b0}}, data_mag} : {{DW{1'b0}}, mag_x};
        cnt    <= '0;
      end
      if (set_err) error <= 1'b1;
      if (state == S_CALC) begin
        acc  <= acc_nxt;
        root <= root_nxt;
        rrem <= rrem_nxt;
        cnt  <= cnt + CW'(1);
        if (calc_last) begin
          result    <= fin_res;
          remainder <= fin_rem;
          overflow  <= fin_ovf;
        end
      end
    end
  end

endmodule
